mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 139 +++++++++++++
 tb/tb_mem_arb.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// ============================================================================
// mem_arb : two-requester (fetch / load-store) single-port RAM arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arb #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              MEM_ARB_clk,
    input  logic              MEM_ARB_rst,
    input  logic              MEM_ARB_if_req,
    input  logic [31:0]       MEM_ARB_if_addr,
    input  logic              MEM_ARB_if_flush,
    output logic              MEM_ARB_if_gnt,
    output logic              MEM_ARB_if_valid,
    output logic [DATA_W-1:0] MEM_ARB_if_data,
    input  logic              MEM_ARB_ls_req,
    input  logic              MEM_ARB_ls_we,
    input  logic [31:0]       MEM_ARB_ls_addr,
    input  logic [DATA_W-1:0] MEM_ARB_ls_wdata,
    output logic              MEM_ARB_ls_gnt,
    output logic              MEM_ARB_ls_valid,
    output logic [DATA_W-1:0] MEM_ARB_ls_rdata,
    output logic [ADDR_W-1:0] MEM_ARB_ram_addr,
    output logic              MEM_ARB_ram_we,
    output logic [DATA_W-1:0] MEM_ARB_ram_wdata,
    input  logic [DATA_W-1:0] MEM_ARB_ram_rdata
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY_IF = 2'd1;
    localparam logic [1:0] c_BUSY_LS = 2'd2;

    logic [1:0]        r_state;
    logic              r_ptr_ls;
    logic              r_if_gnt;
    logic              r_ls_gnt;
    logic              r_if_valid;
    logic              r_ls_valid;
    logic [DATA_W-1:0] r_if_data;
    logic [DATA_W-1:0] r_ls_rdata;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_wdata;

    logic w_idle;
    logic w_if_elig;
    logic w_ls_elig;
    logic w_contend;
    logic w_pick_if;
    logic w_pick_ls;
    logic w_unused;

    // A flushed fetch is not a candidate, so LS wins regardless of the pointer.
    assign w_idle    = (r_state == c_IDLE);
    assign w_if_elig = w_idle & MEM_ARB_if_req & ~MEM_ARB_if_flush;
    assign w_ls_elig = w_idle & MEM_ARB_ls_req;
    assign w_contend = w_if_elig & w_ls_elig;
    assign w_pick_if = w_if_elig & (~w_ls_elig | ~r_ptr_ls);
    assign w_pick_ls = w_ls_elig & ~w_pick_if;

    // Byte-offset and upper address bits never reach the word-addressed RAM.
    assign w_unused = ^{MEM_ARB_if_addr[31:ADDR_W+2], MEM_ARB_if_addr[1:0],
                        MEM_ARB_ls_addr[31:ADDR_W+2], MEM_ARB_ls_addr[1:0]};

    always_ff @(posedge MEM_ARB_clk) begin
        if (!MEM_ARB_rst) begin
            r_state     <= c_IDLE;
            r_ptr_ls    <= 1'b0;
            r_if_gnt    <= 1'b0;
            r_ls_gnt    <= 1'b0;
            r_if_valid  <= 1'b0;
            r_ls_valid  <= 1'b0;
            r_if_data   <= '0;
            r_ls_rdata  <= '0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            r_if_gnt   <= 1'b0;
            r_ls_gnt   <= 1'b0;
            r_if_valid <= 1'b0;
            r_ls_valid <= 1'b0;
            r_ram_we   <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_pick_if) begin
                        r_if_gnt   <= 1'b1;
                        r_ram_addr <= MEM_ARB_if_addr[ADDR_W+1:2];
                        r_state    <= c_BUSY_IF;
                    end else if (w_pick_ls) begin
                        r_ls_gnt    <= 1'b1;
                        r_ram_addr  <= MEM_ARB_ls_addr[ADDR_W+1:2];
                        r_ram_we    <= MEM_ARB_ls_we;
                        r_ram_wdata <= MEM_ARB_ls_wdata;
                        r_state     <= c_BUSY_LS;
                    end
                    // Pointer favours the loser of a contended grant.
                    if (w_contend) begin
                        r_ptr_ls <= w_pick_if;
                    end
                end
                c_BUSY_IF: begin
                    if (!MEM_ARB_if_flush) begin
                        r_if_valid <= 1'b1;
                        r_if_data  <= MEM_ARB_ram_rdata;
                    end
                    r_state <= c_IDLE;
                end
                c_BUSY_LS: begin
                    r_ls_valid <= 1'b1;
                    // r_ram_we still marks the access in progress as a store.
                    if (!r_ram_we) begin
                        r_ls_rdata <= MEM_ARB_ram_rdata;
                    end
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign MEM_ARB_if_gnt    = r_if_gnt;
    assign MEM_ARB_ls_gnt    = r_ls_gnt;
    assign MEM_ARB_if_valid  = r_if_valid;
    assign MEM_ARB_ls_valid  = r_ls_valid;
    assign MEM_ARB_if_data   = r_if_data;
    assign MEM_ARB_ls_rdata  = r_ls_rdata;
    assign MEM_ARB_ram_addr  = r_ram_addr;
    assign MEM_ARB_ram_we    = r_ram_we;
    assign MEM_ARB_ram_wdata = r_ram_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arb.sv
// ============================================================================
// tb_mem_arb : directed and randomized checks of mem_arb against a RAM model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arb;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int NCYC   = 300;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, if_flush, if_gnt, if_valid;
    logic [31:0]       if_addr;
    logic [DATA_W-1:0] if_data;
    logic              ls_req, ls_we, ls_gnt, ls_valid;
    logic [31:0]       ls_addr;
    logic [DATA_W-1:0] ls_wdata, ls_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    // RAM with a preload port used only while the DUT is in reset
    logic [DATA_W-1:0] mem [0:63];
    logic              pl_we = 1'b0;
    logic [5:0]        pl_addr = '0;
    logic [DATA_W-1:0] pl_data = '0;
    logic [DATA_W-1:0] m_mem [0:63];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .MEM_ARB_clk      (clk),
        .MEM_ARB_rst      (rst),
        .MEM_ARB_if_req   (if_req),
        .MEM_ARB_if_addr  (if_addr),
        .MEM_ARB_if_flush (if_flush),
        .MEM_ARB_if_gnt   (if_gnt),
        .MEM_ARB_if_valid (if_valid),
        .MEM_ARB_if_data  (if_data),
        .MEM_ARB_ls_req   (ls_req),
        .MEM_ARB_ls_we    (ls_we),
        .MEM_ARB_ls_addr  (ls_addr),
        .MEM_ARB_ls_wdata (ls_wdata),
        .MEM_ARB_ls_gnt   (ls_gnt),
        .MEM_ARB_ls_valid (ls_valid),
        .MEM_ARB_ls_rdata (ls_rdata),
        .MEM_ARB_ram_addr (ram_addr),
        .MEM_ARB_ram_we   (ram_we),
        .MEM_ARB_ram_wdata(ram_wdata),
        .MEM_ARB_ram_rdata(ram_rdata)
    );

    task automatic idle_inputs();
        if_req = 0; if_flush = 0; if_addr = '0;
        ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
    endtask

    // Called with rst=0; loads the RAM and the bench's copy of it
    task automatic preload();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pl_we = 1; pl_addr = 6'(i);
            pl_data = (i == 3) ? 32'h00A00093 : $urandom;
            m_mem[i] = pl_data;
        end
        @(negedge clk);
        pl_we = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        preload();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({if_gnt, ls_gnt, if_valid, ls_valid, ram_we} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {if_gnt, ls_gnt, if_valid, ls_valid, ram_we});
        else n_pass++;
        n_checks++;
        if (ram_addr !== '0 || ram_wdata !== '0)
            $display("FAIL reset_ram: addr %h wdata %h want 0", ram_addr, ram_wdata);
        else n_pass++;
        n_checks++;
        if (if_data !== '0 || ls_rdata !== '0)
            $display("FAIL reset_data: if_data %h ls_rdata %h want 0", if_data, ls_rdata);
        else n_pass++;
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        if_req = 1; if_addr = 32'h0000000C;
        @(negedge clk);
        if_req = 0;
        n_checks++;
        if (if_gnt !== 1 || ls_gnt !== 0 || ram_addr !== 6'd3 || ram_we !== 0)
            $display("FAIL fetch_gnt: gnt %b/%b addr %0d we %b want 1/0 3 0", if_gnt, ls_gnt, ram_addr, ram_we);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (if_valid !== 1 || if_data !== 32'h00A00093 || if_gnt !== 0)
            $display("FAIL fetch_valid: valid %b data %h gnt %b want 1 00a00093 0", if_valid, if_data, if_gnt);
        else n_pass++;
    endtask

    // Both held high: IF, LS, IF, LS, one grant every second cycle
    task automatic test_contention();
        logic [3:0] exp;
        if_req = 1; if_addr = 32'h00000040;
        ls_req = 1; ls_we = 0; ls_addr = 32'h00000020;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 7) idle_inputs();
            exp = {(k == 0 || k == 4), (k == 2 || k == 6), (k == 1 || k == 5), (k == 3 || k == 7)};
            n_checks++;
            if ({if_gnt, ls_gnt, if_valid, ls_valid} !== exp)
                $display("FAIL contend_seq k=%0d: gnt/valid %b want %b", k, {if_gnt, ls_gnt, if_valid, ls_valid}, exp);
            else n_pass++;
            if (k % 2 == 0) begin
                n_checks++;
                if (ram_addr !== ((k % 4 == 0) ? 6'd16 : 6'd8))
                    $display("FAIL contend_addr k=%0d: addr %0d", k, ram_addr);
                else n_pass++;
            end
            if (k == 5 || k == 7) begin
                n_checks++;
                if (if_data !== m_mem[16] || ls_rdata !== m_mem[8])
                    $display("FAIL contend_data k=%0d: if %h ls %h want %h %h", k, if_data, ls_rdata, m_mem[16], m_mem[8]);
                else n_pass++;
            end
        end
        @(negedge clk);
        n_checks++;
        if ({if_gnt, ls_gnt} !== 2'b00)
            $display("FAIL contend_tail: gnt %b want 00", {if_gnt, ls_gnt});
        else n_pass++;
    endtask

    task automatic test_store();
        ls_req = 1; ls_we = 1; ls_addr = 32'h00000014; ls_wdata = 32'hDEADBEEF;
        @(negedge clk);
        idle_inputs();
        n_checks++;
        if (ls_gnt !== 1 || ram_we !== 1 || ram_addr !== 6'd5 || ram_wdata !== 32'hDEADBEEF)
            $display("FAIL store_t1: gnt %b we %b addr %0d wdata %h want 1 1 5 deadbeef", ls_gnt, ram_we, ram_addr, ram_wdata);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ls_valid !== 1 || ram_we !== 0 || ls_rdata !== m_mem[8])
            $display("FAIL store_t2: valid %b we %b rdata %h want 1 0 %h", ls_valid, ram_we, ls_rdata, m_mem[8]);
        else n_pass++;
        n_checks++;
        if (mem[5] !== 32'hDEADBEEF)
            $display("FAIL store_ram: word5 %h want deadbeef", mem[5]);
        else n_pass++;
        m_mem[5] = 32'hDEADBEEF;
    endtask

    task automatic test_flush();
        if_req = 1; if_addr = 32'h00000008;
        @(negedge clk);
        if_req = 0; if_flush = 1;
        n_checks++;
        if (if_gnt !== 1)
            $display("FAIL flush_gnt: gnt %b want 1", if_gnt);
        else n_pass++;
        @(negedge clk);
        if_flush = 0; if_req = 1; if_addr = 32'h00000004;
        n_checks++;
        if (if_valid !== 0 || if_data !== m_mem[16])
            $display("FAIL flush_kill: valid %b data %h want 0 %h", if_valid, if_data, m_mem[16]);
        else n_pass++;
        @(negedge clk);
        if_req = 0;
        n_checks++;
        if (if_gnt !== 1 || ram_addr !== 6'd1)
            $display("FAIL flush_next_gnt: gnt %b addr %0d want 1 1", if_gnt, ram_addr);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (if_valid !== 1 || if_data !== m_mem[1])
            $display("FAIL flush_next_valid: valid %b data %h want 1 %h", if_valid, if_data, m_mem[1]);
        else n_pass++;
    endtask

    // Flushed IF request in IDLE loses to LS even though the pointer favours IF
    task automatic test_flush_idle();
        if_req = 1; if_addr = 32'h0000000C; if_flush = 1;
        ls_req = 1; ls_we = 0; ls_addr = 32'h00000000;
        @(negedge clk);
        idle_inputs();
        n_checks++;
        if (ls_gnt !== 1 || if_gnt !== 0 || ram_addr !== 6'd0)
            $display("FAIL flush_idle: if/ls gnt %b%b addr %0d want 01 0", if_gnt, ls_gnt, ram_addr);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ls_valid !== 1 || ls_rdata !== m_mem[0] || if_valid !== 0)
            $display("FAIL flush_idle_data: valid %b rdata %h want 1 %h", ls_valid, ls_rdata, m_mem[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        ls_req = 1; ls_we = 1; ls_addr = 32'h00000018; ls_wdata = 32'h12345678;
        @(negedge clk);
        idle_inputs();
        n_checks++;
        if (ram_we !== 1 || ls_gnt !== 1)
            $display("FAIL rstmid_busy: we %b gnt %b want 1 1", ram_we, ls_gnt);
        else n_pass++;
        rst = 0;
        @(negedge clk);
        n_checks++;
        if ({if_gnt, ls_gnt, if_valid, ls_valid, ram_we} !== 5'b0 || ram_addr !== '0 ||
            ram_wdata !== '0 || if_data !== '0 || ls_rdata !== '0)
            $display("FAIL rstmid_zero: ctrl %b addr %h wdata %h ifd %h lsd %h want all 0",
                     {if_gnt, ls_gnt, if_valid, ls_valid, ram_we}, ram_addr, ram_wdata, if_data, ls_rdata);
        else n_pass++;
        rst = 1;
        @(negedge clk);
        n_checks++;
        if (ls_valid !== 0 || ram_we !== 0)
            $display("FAIL rstmid_after: valid %b we %b want 0 0", ls_valid, ram_we);
        else n_pass++;
    endtask

    // Transaction-level model: each cycle, either an access in flight finishes,
    // or an arbitration happens using the round-robin preference.
    logic        e_gi [0:NCYC+1], e_gl [0:NCYC+1], e_vi [0:NCYC+1], e_vl [0:NCYC+1], e_we [0:NCYC+1];
    logic [5:0]  e_addr [0:NCYC+1];
    logic [31:0] e_wd [0:NCYC+1], e_ifd [0:NCYC+1], e_lsd [0:NCYC+1];

    task automatic test_random();
        int         pend;
        logic       pend_we, fav_if;
        logic [5:0] pend_idx;
        logic [31:0] pend_wd;
        int         win;
        rst = 0;
        idle_inputs();
        preload();
        @(negedge clk);
        rst = 1;
        e_gi[0] = 0; e_gl[0] = 0; e_vi[0] = 0; e_vl[0] = 0; e_we[0] = 0;
        e_addr[0] = '0; e_wd[0] = '0; e_ifd[0] = '0; e_lsd[0] = '0;
        pend = 0; fav_if = 1; pend_we = 0; pend_idx = '0; pend_wd = '0;
        for (int c = 0; c < NCYC; c++) begin
            if (c > 0) @(negedge clk);
            n_checks++;
            if ({if_gnt, ls_gnt, if_valid, ls_valid, ram_we} !== {e_gi[c], e_gl[c], e_vi[c], e_vl[c], e_we[c]})
                $display("FAIL rnd_ctrl c=%0d: gi gl vi vl we %b want %b", c,
                         {if_gnt, ls_gnt, if_valid, ls_valid, ram_we}, {e_gi[c], e_gl[c], e_vi[c], e_vl[c], e_we[c]});
            else n_pass++;
            n_checks++;
            if (ram_addr !== e_addr[c] || ram_wdata !== e_wd[c])
                $display("FAIL rnd_ram c=%0d: addr %0d wdata %h want %0d %h", c, ram_addr, ram_wdata, e_addr[c], e_wd[c]);
            else n_pass++;
            n_checks++;
            if (if_data !== e_ifd[c] || ls_rdata !== e_lsd[c])
                $display("FAIL rnd_data c=%0d: ifd %h lsd %h want %h %h", c, if_data, ls_rdata, e_ifd[c], e_lsd[c]);
            else n_pass++;

            // Requesters hold a request until its grant, then may issue another
            if (!if_req || e_gi[c]) begin
                if_req = $urandom_range(0, 1) == 1; if_addr = $urandom;
            end
            if (!ls_req || e_gl[c]) begin
                ls_req = $urandom_range(0, 1) == 1; ls_addr = $urandom;
                ls_we = $urandom_range(0, 2) == 0; ls_wdata = $urandom;
            end
            if_flush = $urandom_range(0, 4) == 0;

            e_gi[c+1] = 0; e_gl[c+1] = 0; e_vi[c+1] = 0; e_vl[c+1] = 0; e_we[c+1] = 0;
            e_addr[c+1] = e_addr[c]; e_wd[c+1] = e_wd[c];
            e_ifd[c+1] = e_ifd[c]; e_lsd[c+1] = e_lsd[c];
            if (pend == 1) begin
                if (!if_flush) begin
                    e_vi[c+1] = 1; e_ifd[c+1] = m_mem[pend_idx];
                end
                pend = 0;
            end else if (pend == 2) begin
                e_vl[c+1] = 1;
                if (pend_we) m_mem[pend_idx] = pend_wd;
                else e_lsd[c+1] = m_mem[pend_idx];
                pend = 0;
            end else begin
                if ((if_req && !if_flush) && ls_req) begin
                    win = fav_if ? 1 : 2;
                    fav_if = (win == 2);
                end else if (if_req && !if_flush) win = 1;
                else if (ls_req) win = 2;
                else win = 0;
                if (win == 1) begin
                    e_gi[c+1] = 1; pend_idx = 6'((if_addr / 4) % 64);
                    e_addr[c+1] = pend_idx; pend = 1;
                end else if (win == 2) begin
                    e_gl[c+1] = 1; pend_idx = 6'((ls_addr / 4) % 64);
                    e_addr[c+1] = pend_idx; e_we[c+1] = ls_we; e_wd[c+1] = ls_wdata;
                    pend_we = ls_we; pend_wd = ls_wdata; pend = 2;
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        test_reset();
        test_fetch();
        test_contention();
        test_store();
        test_flush();
        test_flush_idle();
        test_reset_mid();
        test_random();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
